timer_scheduler: RTL

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/timer_scheduler.sv
// One-shot timer scheduler: arms deadlines against a free-running microsecond count and
// streams expiry events through a valid/ready slot with round-robin arbitration.
module timer_scheduler #(
  parameter int unsigned P_NUM_TIMERS    = 4,
  parameter int unsigned P_COUNTER_WIDTH = 32
) (
  input  logic                            I_INPUT_CLK,
  input  logic                            I_NRESET,
  input  logic [P_COUNTER_WIDTH-1:0]      I_MICROSEC_COUNT,
  input  logic                            I_ARM_VALID,
  input  logic [$clog2(P_NUM_TIMERS)-1:0] I_ARM_ID,
  input  logic [P_COUNTER_WIDTH-1:0]      I_ARM_DELAY,
  output logic                            O_ARM_READY,
  output logic                            O_ARM_ERR,
  input  logic                            I_CANCEL_VALID,
  input  logic [$clog2(P_NUM_TIMERS)-1:0] I_CANCEL_ID,
  output logic                            O_EXP_VALID,
  output logic [$clog2(P_NUM_TIMERS)-1:0] O_EXP_ID,
  input  logic                            I_EXP_READY,
  output logic [P_NUM_TIMERS-1:0]         O_ACTIVE
);

  localparam int unsigned N   = P_NUM_TIMERS;
  localparam int unsigned W   = P_COUNTER_WIDTH;
  localparam int unsigned IdW = $clog2(P_NUM_TIMERS);
  localparam logic [W-1:0] HalfRange = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [0:0] {StIdle, StLoad} arm_state_e;

  arm_state_e     arm_state_q, arm_state_d;
  logic           arm_ready_q, arm_ready_d;
  logic           arm_err_q, arm_err_d;
  logic [IdW-1:0] hold_id_q, hold_id_d;
  logic [W-1:0]   hold_delay_q, hold_delay_d;
  logic [W-1:0]   hold_count_q, hold_count_d;
  logic [W-1:0]   deadline_q [N];
  logic [W-1:0]   deadline_d [N];
  logic [N-1:0]   active_q, active_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           exp_valid_q, exp_valid_d;
  logic [IdW-1:0] exp_id_q, exp_id_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;

  logic           load_ok, handshake, slot_free, cancel_hit, grant_found;
  logic [IdW-1:0] grant_id;
  logic [N-1:0]   expired, hs_mask, cancel_mask, load_mask, cand;

  always_comb begin
    arm_state_d  = arm_state_q;
    hold_id_d    = hold_id_q;
    hold_delay_d = hold_delay_q;
    hold_count_d = hold_count_q;
    arm_err_d    = 1'b0;
    load_ok      = 1'b0;
    case (arm_state_q)
      StIdle: begin
        if (I_ARM_VALID && arm_ready_q) begin
          arm_state_d  = StLoad;
          hold_id_d    = I_ARM_ID;
          hold_delay_d = I_ARM_DELAY;
          hold_count_d = I_MICROSEC_COUNT;
        end
      end
      StLoad: begin
        arm_state_d = StIdle;
        // Delays of half the counter range or more would alias as already-expired.
        if (hold_delay_q[W-1]) arm_err_d = 1'b1;
        else                   load_ok   = 1'b1;
      end
      default: arm_state_d = StIdle;
    endcase
    arm_ready_d = (arm_state_d == StIdle);
  end

  always_comb begin
    handshake = exp_valid_q & I_EXP_READY;
    for (int unsigned i = 0; i < N; i++) begin
      // Wrap-safe: due once (count - deadline) is non-negative as a signed value.
      expired[i]     = active_q[i] && ((I_MICROSEC_COUNT - deadline_q[i]) < HalfRange);
      hs_mask[i]     = handshake && (exp_id_q == IdW'(i));
      cancel_mask[i] = I_CANCEL_VALID && (I_CANCEL_ID == IdW'(i));
      load_mask[i]   = load_ok && (hold_id_q == IdW'(i));
    end
  end

  // Priority per timer: load > cancel > expiry > handshake clear.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      deadline_d[i] = deadline_q[i];
      active_d[i]   = active_q[i];
      pending_d[i]  = pending_q[i] & ~hs_mask[i];
      if (expired[i]) begin
        active_d[i]  = 1'b0;
        pending_d[i] = 1'b1;
      end
      if (cancel_mask[i]) begin
        active_d[i]  = 1'b0;
        pending_d[i] = 1'b0;
      end
      if (load_mask[i]) begin
        deadline_d[i] = hold_count_q + hold_delay_q;
        active_d[i]   = 1'b1;
        pending_d[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    slot_free   = ~exp_valid_q | handshake;
    cancel_hit  = I_CANCEL_VALID && exp_valid_q && (I_CANCEL_ID == exp_id_q);
    cand        = pending_q & ~hs_mask & ~cancel_mask & ~load_mask;
    grant_found = 1'b0;
    grant_id    = '0;
    // Round-robin: ids at or above the pointer first, then the wrapped-around ones.
    for (int unsigned i = 0; i < N; i++) begin
      if (!grant_found && cand[i] && (IdW'(i) >= rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_id    = IdW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!grant_found && cand[i] && (IdW'(i) < rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_id    = IdW'(i);
      end
    end
    exp_valid_d = exp_valid_q;
    exp_id_d    = exp_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (slot_free) begin
      exp_valid_d = grant_found;
      if (grant_found) begin
        exp_id_d = grant_id;
        rr_ptr_d = (grant_id == IdW'(N - 1)) ? '0 : grant_id + 1'b1;
      end
    end else if (cancel_hit) begin
      exp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge I_INPUT_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      arm_state_q  <= StIdle;
      arm_ready_q  <= 1'b0;
      arm_err_q    <= 1'b0;
      hold_id_q    <= '0;
      hold_delay_q <= '0;
      hold_count_q <= '0;
      for (int unsigned i = 0; i < N; i++) deadline_q[i] <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      exp_valid_q  <= 1'b0;
      exp_id_q     <= '0;
      rr_ptr_q     <= '0;
    end else begin
      arm_state_q  <= arm_state_d;
      arm_ready_q  <= arm_ready_d;
      arm_err_q    <= arm_err_d;
      hold_id_q    <= hold_id_d;
      hold_delay_q <= hold_delay_d;
      hold_count_q <= hold_count_d;
      for (int unsigned i = 0; i < N; i++) deadline_q[i] <= deadline_d[i];
      active_q     <= active_d;
      pending_q    <= pending_d;
      exp_valid_q  <= exp_valid_d;
      exp_id_q     <= exp_id_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign O_ARM_READY = arm_ready_q;
  assign O_ARM_ERR   = arm_err_q;
  assign O_EXP_VALID = exp_valid_q;
  assign O_EXP_ID    = exp_id_q;
  assign O_ACTIVE    = active_q;

endmodule
